// File: rtl/memory_access_top.sv
// Memory-access pipeline stage: drives loads/stores onto a req/gnt/rvalid
// data-memory port, aligns and extends load data, forwards results to decode
// and registers them into writeback. Stalls the pipe while a transaction is open.
// Optional build macro: MA_MISALIGN_TRAP_EN (misaligned accesses are squashed
// without touching memory and flagged on ma_misalign).
module memory_access_top #(
    parameter int unsigned DM_AW       = 32,
    parameter logic [31:0] BUBBLE_INST = 32'h00000013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ma_inst,
    input  logic [31:0]      ma_pc,
    input  logic [31:0]      ma_dat,
    input  logic [31:0]      ma_rd2,
    output logic             ma_stall,
    output logic             ma_fwd_we,
    output logic [4:0]       ma_fwd_dst,
    output logic [31:0]      ma_fwd_dat,
    output logic             dm_req,
    output logic             dm_we,
    output logic [DM_AW-1:0] dm_addr,
    output logic [3:0]       dm_be,
    output logic [31:0]      dm_wdat,
    input  logic             dm_gnt,
    input  logic             dm_rvalid,
    input  logic [31:0]      dm_rdat,
`ifdef MA_MISALIGN_TRAP_EN
    output logic             ma_misalign,
`endif
    output logic [31:0]      wb_inst,
    output logic [31:0]      wb_pc,
    output logic [31:0]      wb_dat
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [6:0]  opcode;
    logic [1:0]  size;
    logic        zext;
    logic [1:0]  a;
    logic        ld, st, br, mem;
    logic        misalign;
    logic        mem_go;
    logic        done;
    logic [1:0]  state_q, state_d;
    logic [31:0] shifted;
    logic [31:0] ld_res;
    logic        unused_bits;

    assign opcode = ma_inst[6:0];
    assign size   = ma_inst[13:12];
    assign zext   = ma_inst[14];
    assign a      = ma_dat[1:0];
    assign ld     = (opcode == OP_LOAD);
    assign st     = (opcode == OP_STORE);
    assign br     = (opcode == OP_BRANCH);
    assign mem    = ld | st;

    // Upper instruction bits carry no meaning for this stage.
    assign unused_bits = ^{ma_inst[31:15], ma_dat};

`ifdef MA_MISALIGN_TRAP_EN
    assign misalign    = mem & (((size == 2'b01) & a[0]) | ((size == 2'b10) & (a != 2'b00)));
    assign ma_misalign = misalign;
`else
    assign misalign = 1'b0;
`endif

    // A squashed misaligned access never reaches the memory port.
    assign mem_go = mem & ~misalign;

    // Address and write lanes come straight from the held execute outputs.
    assign dm_addr = {ma_dat[DM_AW-1:2], 2'b00};
    assign dm_we   = st;

    // Byte enables and lane-replicated store data.
    always_comb begin
        dm_be   = 4'b1111;
        dm_wdat = ma_rd2;
        case (size)
            2'b00: begin
                dm_be   = 4'b0001 << a;
                dm_wdat = {4{ma_rd2[7:0]}};
            end
            2'b01: begin
                dm_be   = a[1] ? 4'b1100 : 4'b0011;
                dm_wdat = {2{ma_rd2[15:0]}};
            end
            default: begin
                dm_be   = 4'b1111;
                dm_wdat = ma_rd2;
            end
        endcase
    end

    // Load alignment and sign/zero extension.
    always_comb begin
        shifted = dm_rdat;
        ld_res  = dm_rdat;
        case (size)
            2'b00: begin
                shifted = dm_rdat >> {a, 3'b000};
                ld_res  = zext ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                shifted = dm_rdat >> {a[1], 4'b0000};
                ld_res  = zext ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: begin
                shifted = dm_rdat;
                ld_res  = dm_rdat;
            end
        endcase
    end

    // Transaction FSM: request phase until gnt, then loads wait for rvalid.
    always_comb begin
        state_d = state_q;
        dm_req  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                dm_req = mem_go;
                if (mem_go) begin
                    if (dm_gnt) begin
                        if (ld) state_d = WAIT;
                        else    done    = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                dm_req = 1'b1;
                if (dm_gnt) begin
                    if (ld) begin
                        state_d = WAIT;
                    end else begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT: begin
                if (dm_rvalid) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ma_stall   = mem_go & ~done;
    assign ma_fwd_we  = ~st & ~br & ~ma_stall & ~misalign;
    assign ma_fwd_dst = ma_inst[11:7];
    assign ma_fwd_dat = ld ? ld_res : ma_dat;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Writeback register; a bubble goes in whenever nothing valid completes.
    always_ff @(posedge clk) begin
        if (rst || ma_stall || misalign) begin
            wb_inst <= BUBBLE_INST;
            wb_pc   <= 32'h0;
            wb_dat  <= 32'h0;
        end else begin
            wb_inst <= ma_inst;
            wb_pc   <= ma_pc;
            wb_dat  <= ma_fwd_dat;
        end
    end

endmodule

// File: tb/tb_memory_access_top.sv
// Self-checking bench for memory_access_top with a randomized memory responder
// and a behavioural reference for lanes, alignment, latency and writeback.
module tb_memory_access_top;

    localparam logic [31:0] BUBBLE = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ma_inst, ma_pc, ma_dat, ma_rd2;
    logic        ma_stall, ma_fwd_we;
    logic [4:0]  ma_fwd_dst;
    logic [31:0] ma_fwd_dat;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdat;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdat;
    logic [31:0] wb_inst, wb_pc, wb_dat;
`ifdef MA_MISALIGN_TRAP_EN
    logic        ma_misalign;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memory_access_top dut (
        .clk        (clk),
        .rst        (rst),
        .ma_inst    (ma_inst),
        .ma_pc      (ma_pc),
        .ma_dat     (ma_dat),
        .ma_rd2     (ma_rd2),
        .ma_stall   (ma_stall),
        .ma_fwd_we  (ma_fwd_we),
        .ma_fwd_dst (ma_fwd_dst),
        .ma_fwd_dat (ma_fwd_dat),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_be      (dm_be),
        .dm_wdat    (dm_wdat),
        .dm_gnt     (dm_gnt),
        .dm_rvalid  (dm_rvalid),
        .dm_rdat    (dm_rdat),
`ifdef MA_MISALIGN_TRAP_EN
        .ma_misalign(ma_misalign),
`endif
        .wb_inst    (wb_inst),
        .wb_pc      (wb_pc),
        .wb_dat     (wb_dat)
    );

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [4:0] rd);
        return {17'b0, f3, rd, op};
    endfunction

    // Reference: pick the addressed byte/half out of the word, then extend.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = w[16*a[1] +: 16];
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdat(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // One instruction through the stage with a memory that grants after gnt_dly
    // cycles and returns load data rval_dly cycles after the grant.
    task automatic run_access(input string name, input logic [31:0] inst, input logic [31:0] pc,
                              input logic [31:0] dat, input logic [31:0] rd2, input int gnt_dly,
                              input int rval_dly, input logic [31:0] rdat);
        logic        is_ld, is_st, is_br, is_mem, mis, granted, fin, exp_req;
        logic [2:0]  f3;
        logic [1:0]  a;
        logic [31:0] exp_res;
        int          cyc, gcyc, stalls, reqs, bad_req, exp_stalls;
        f3     = inst[14:12];
        a      = dat[1:0];
        is_ld  = inst[6:0] == 7'b0000011;
        is_st  = inst[6:0] == 7'b0100011;
        is_br  = inst[6:0] == 7'b1100011;
        is_mem = is_ld || is_st;
        mis    = 1'b0;
`ifdef MA_MISALIGN_TRAP_EN
        mis = is_mem && ((f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00));
`endif
        exp_res = is_ld ? model_load(f3, a, rdat) : dat;
        ma_inst = inst; ma_pc = pc; ma_dat = dat; ma_rd2 = rd2;
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdat = $urandom;
        granted = 0; fin = 0; cyc = 0; gcyc = 0; stalls = 0; reqs = 0; bad_req = 0;
        while (!fin && cyc < 64) begin
            if (is_mem && !mis) begin
                if (!granted) begin
                    dm_gnt    = (cyc == gnt_dly);
                    dm_rvalid = 1'($urandom_range(0, 1)); // stray rvalid must be ignored
                    dm_rdat   = $urandom;
                end else begin
                    dm_gnt    = 1'b0;
                    dm_rvalid = (cyc == gcyc + rval_dly);
                    dm_rdat   = dm_rvalid ? rdat : $urandom;
                end
            end else begin
                dm_rvalid = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            exp_req = is_mem && !mis && !granted;
            if (dm_req !== exp_req) bad_req++;
            if (dm_req) reqs++;
            if (ma_stall) stalls++;
            if (exp_req && cyc == 0) begin
                checks++;
                if (dm_addr !== {dat[31:2], 2'b00} || dm_be !== model_be(f3, a) ||
                    dm_we !== is_st) begin
                    failures++;
                    $display("FAIL %s port: addr=%h be=%b we=%b want addr=%h be=%b we=%b", name,
                             dm_addr, dm_be, dm_we, {dat[31:2], 2'b00}, model_be(f3, a), is_st);
                end
                if (is_st) begin
                    checks++;
                    if (dm_wdat !== model_wdat(f3, rd2)) begin
                        failures++;
                        $display("FAIL %s wdat: got %h want %h", name, dm_wdat,
                                 model_wdat(f3, rd2));
                    end
                end
            end
            if (exp_req && dm_gnt) begin
                granted = 1;
                gcyc    = cyc;
                if (is_st) fin = 1;
            end else if (granted && dm_rvalid) begin
                fin = 1;
            end
            if (!is_mem || mis) fin = 1;
            if (fin) begin
                checks++;
                if (ma_fwd_we !== (!is_st && !is_br && !mis) || ma_fwd_dst !== inst[11:7] ||
                    (!is_st && !mis && ma_fwd_dat !== exp_res)) begin
                    failures++;
                    $display("FAIL %s fwd: we=%b dst=%0d dat=%h want we=%b dst=%0d dat=%h", name,
                             ma_fwd_we, ma_fwd_dst, ma_fwd_dat, (!is_st && !is_br && !mis),
                             inst[11:7], exp_res);
                end
`ifdef MA_MISALIGN_TRAP_EN
                checks++;
                if (ma_misalign !== mis) begin
                    failures++;
                    $display("FAIL %s misalign: got %b want %b", name, ma_misalign, mis);
                end
`endif
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        dm_gnt = 1'b0;
        dm_rvalid = 1'b0;
        checks++;
        if (!fin) begin
            failures++;
            $display("FAIL %s timeout: no completion after %0d cycles, want completion", name, cyc);
        end
        exp_stalls = (!is_mem || mis) ? 0 : (is_st ? gnt_dly : gnt_dly + rval_dly);
        checks++;
        if (bad_req != 0 || stalls != exp_stalls || reqs != ((is_mem && !mis) ? gnt_dly + 1 : 0))
        begin
            failures++;
            $display("FAIL %s timing: stalls=%0d reqs=%0d badreq=%0d want stalls=%0d reqs=%0d",
                     name, stalls, reqs, bad_req, exp_stalls,
                     (is_mem && !mis) ? gnt_dly + 1 : 0);
        end
        checks++;
        if (mis) begin
            if (wb_inst !== BUBBLE || wb_pc !== 0 || wb_dat !== 0) begin
                failures++;
                $display("FAIL %s wb: inst=%h pc=%h dat=%h want bubble", name, wb_inst, wb_pc,
                         wb_dat);
            end
        end else if (wb_inst !== inst || wb_pc !== pc || wb_dat !== exp_res) begin
            failures++;
            $display("FAIL %s wb: inst=%h pc=%h dat=%h want inst=%h pc=%h dat=%h", name, wb_inst,
                     wb_pc, wb_dat, inst, pc, exp_res);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ma_inst = BUBBLE; ma_pc = 32'h40; ma_dat = 32'h55; ma_rd2 = 0;
        dm_gnt = 0; dm_rvalid = 0; dm_rdat = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (wb_inst !== BUBBLE || wb_pc !== 0 || wb_dat !== 0 || ma_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset: inst=%h pc=%h dat=%h stall=%b want %h 0 0 0", wb_inst, wb_pc,
                     wb_dat, ma_stall, BUBBLE);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        run_access("add", mk(7'b0110011, 3'b000, 5'd5), 32'h100, 32'h1234, 0, 0, 1, 0);
        run_access("sb", mk(7'b0100011, 3'b000, 5'd0), 32'h104, 32'h103, 32'hAB, 2, 1, 0);
        run_access("lb", mk(7'b0000011, 3'b000, 5'd7), 32'h108, 32'h102, 0, 0, 3,
                   32'h00800000);
        run_access("lbu", mk(7'b0000011, 3'b100, 5'd7), 32'h10C, 32'h102, 0, 0, 3,
                   32'h00800000);
        run_access("lh", mk(7'b0000011, 3'b001, 5'd8), 32'h110, 32'h2, 0, 1, 1, 32'h80010000);
        run_access("sw", mk(7'b0100011, 3'b010, 5'd0), 32'h114, 32'h200, 32'hDEADBEEF, 0, 1, 0);
    endtask

    task automatic test_reset_mid;
        ma_inst = mk(7'b0000011, 3'b010, 5'd9); ma_pc = 32'h300; ma_dat = 32'h200;
        dm_gnt = 1'b1; dm_rvalid = 1'b0;
        @(posedge clk);
        #1;
        dm_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if (dm_req !== 1'b0 || ma_stall !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid wait: req=%b stall=%b want 0 1", dm_req, ma_stall);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        dm_rvalid = 1'b1;
        dm_rdat = 32'hCAFEF00D;
        @(negedge clk);
        checks++;
        if (dm_req !== 1'b1 || ma_stall !== 1'b1 || ma_fwd_we !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid idle: req=%b stall=%b fwd_we=%b want 1 1 0", dm_req,
                     ma_stall, ma_fwd_we);
        end
        @(posedge clk);
        #1;
        dm_rvalid = 1'b0;
        checks++;
        if (wb_inst !== BUBBLE || wb_dat !== 0 || wb_pc !== 0) begin
            failures++;
            $display("FAIL rst_mid wb: inst=%h dat=%h want %h 0", wb_inst, wb_dat, BUBBLE);
        end
        // Complete the reissued load so the next test starts clean.
        run_access("rst_mid_redo", ma_inst, ma_pc, ma_dat, 0, 0, 1, 32'h11223344);
    endtask

    task automatic test_misalign;
        run_access("lw_mis", mk(7'b0000011, 3'b010, 5'd3), 32'h400, 32'h101, 0, 0, 1,
                   32'h89ABCDEF);
        run_access("sh_mis", mk(7'b0100011, 3'b001, 5'd0), 32'h404, 32'h103, 32'h1234, 1, 1, 0);
    endtask

    task automatic test_random;
        logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [31:0] inst;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: inst = mk(7'b0110011, 3'($urandom), 5'($urandom));
                1: inst = mk(7'b1100011, 3'($urandom), 5'($urandom));
                2: inst = mk(7'b0000011, ld_f3[$urandom_range(0, 4)], 5'($urandom));
                default: inst = mk(7'b0100011, 3'($urandom_range(0, 2)), 5'($urandom));
            endcase
            run_access("rand", inst, $urandom, $urandom, $urandom, $urandom_range(0, 3),
                       $urandom_range(1, 3), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_misalign();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
